uart_rx_peri: RTL
=================

# uart_rx_peri

UART receiver for the CPU peripheral space, the inbound counterpart of the CPU's UART transmit path on the `Tx` pin. It runs the asynchronous `Rx` pin through a synchronizer and samples 8N1 frames with 16x oversampling. Each received byte is presented as a read-and-acknowledge register pair to the data-memory peripheral bus, with framing-error and overrun status.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits/s.
- `OVS_DIV`, default `CLK_FREQ/(BAUD*16)` (integer truncation; 651 at the defaults): clocks per oversample tick. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last accepted byte.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `rx_ack`  in  1  one-cycle pulse from the peripheral bus: the byte was read.
- `frame_err`  out  1  sticky; the last frame had its stop bit = 0.
- `overrun`  out  1  sticky; a byte arrived while `rx_valid` = 1.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
**Synchronizer**
- `Rx` passes through two flops, both resetting to 1. All logic uses the second flop, `rx_s`.

**Tick counter**
- Counts 0..`OVS_DIV`-1 and emits a `tick` on the wrap.
- Held at 0 in IDLE, and cleared on the cycle the state leaves IDLE.
- The sample counter `sc` (4 bits) counts ticks within a bit.

**State machine**
- IDLE
  - When `rx_s` = 0, go to START and set `sc` = 0.
- START
  - At the 8th tick (mid start bit), sample `rx_s`.
  - If `rx_s` = 1: glitch. Return to IDLE; no flags change.
  - If `rx_s` = 0: go to DATA with `sc` = 0 and bit index 0.
- DATA
  - On every 16th tick, shift `rx_s` into the shift register, LSB first.
  - After bit 7, go to STOP.
- STOP
  - On the 16th tick, sample `rx_s`.
  - If `rx_s` = 1: complete the byte (below) and clear `frame_err`.
  - If `rx_s` = 0: set `frame_err` and discard the byte, leaving `rx_valid` and `rx_data` unchanged. Go to BREAK.
- BREAK
  - Wait for `rx_s` = 1, then go to IDLE.
  - This prevents a held-low line from being read as repeated frames.

**Byte completion**
- If `rx_valid` = 0, or `rx_ack` = 1 in the same cycle: load `rx_data` and set `rx_valid` = 1.
- Otherwise: set `overrun` = 1. The new byte is dropped and `rx_data` keeps the unread byte.

**Acknowledge**
- `rx_ack` clears `rx_valid` and `overrun` on the next edge, unless a completion occurs in the same cycle (see above). In that case `rx_valid` stays 1 and `overrun` stays 0.
- `rx_ack` while `rx_valid` = 0 has no effect.
- `rx_ack` does not clear `frame_err`; only the next good stop bit clears it.

**Reset**
- Reset forces state IDLE and clears all counters.
- Outputs at reset: `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
- Reset asserted mid-frame abandons the frame. After release, reception starts at the next falling edge seen in IDLE. A line already low at release is treated as a start bit.

## Timing
- Bit period = 16·`OVS_DIV` clocks. All samples fall at bit centres, ±1 tick of phase error from edge detection.
- The start edge becomes visible in `rx_s` 2 clocks after `Rx` falls.
- `rx_valid` rises 1 clock after the stop sample, (8+16·9)·`OVS_DIV` = 152·`OVS_DIV` clocks after IDLE exits. Total from the `Rx` fall is 152·`OVS_DIV` + 3 clocks (+0/−`OVS_DIV`).
- `busy` is high from the IDLE exit until the return to IDLE, including BREAK.
- The receiver is ready for the next start bit right after the stop sample, so back-to-back frames with no idle gap are received.
- Tolerated baud mismatch is ≥ ±3%.

## Test plan
Bench parameters: `CLK_FREQ` = 1_600_000, `BAUD` = 10_000, giving `OVS_DIV` = 10 and a 160-clock bit.
- **Single byte:** reset low for 5 clocks, then send 0xA5.
  - `rx_data` = 0xA5 and `rx_valid` = 1 at 1523 ± 10 clocks after the start edge.
  - `frame_err` = 0 and `overrun` = 0.
  - Pulse `rx_ack` → `rx_valid` = 0 on the next clock.
- **Glitch rejection:** drive `Rx` low for 40 clocks, then high.
  - `busy` pulses, then returns to 0; no flag changes.
  - A following 0x3C is received correctly.
- **Framing error:** send 0x55 with stop = 0 and hold the line low for 400 clocks.
  - `frame_err` = 1 and `rx_valid` unchanged.
  - `busy` stays 1 until the line goes high.
  - The next good byte 0x12 clears `frame_err`.
- **Overrun:** send 0x11 then 0x22 back-to-back with no ack.
  - `rx_data` = 0x11, `overrun` = 1.
  - `rx_ack` clears both `rx_valid` and `overrun`.
- **Ack collision:** with 0x11 pending, pulse `rx_ack` on exactly the completion cycle of 0x22.
  - `rx_data` = 0x22, `rx_valid` = 1, `overrun` = 0.
- **Reset mid-frame:** assert `rst` = 0 during data bit 4 of 0xFF.
  - All outputs return to their reset values immediately.
  - A subsequent 0x81 sent after release is received correctly.

Source files
------------

// File: rtl/uart_rx_peri.sv
// uart_rx_peri: 8N1 UART receiver with 16x oversampling for the CPU
// peripheral bus; read/ack byte register with framing and overrun status.
module uart_rx_peri #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(OVS_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;
    state_t next_state;

    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    sc;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;

    logic sc_clr;
    logic shift_en;
    logic stop_good;
    logic stop_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (state != S_IDLE) && (div_cnt == DIV_MAX);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sc_clr     = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    next_state = S_START;
                    sc_clr     = 1'b1;
                end
            end
            S_START: begin
                if (tick && (sc == 4'd7)) begin
                    sc_clr     = 1'b1;
                    next_state = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && (sc == 4'd15)) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next_state = S_STOP;
                        sc_clr     = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick && (sc == 4'd15)) begin
                    if (rx_s) begin
                        stop_good  = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Oversample divider restarts on every IDLE exit to align with the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc <= 4'd0;
        end else if ((state == S_IDLE) || sc_clr) begin
            sc <= 4'd0;
        end else if (tick) begin
            sc <= sc + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

    // A completion that coincides with an ack counts as a fresh read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (stop_good) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
                overrun  <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else if (stop_bad) begin
            frame_err <= 1'b1;
        end else if (stop_good) begin
            frame_err <= 1'b0;
        end
    end

endmodule
